// File: rtl/h80cpu_bus_arb_pkg.sv
// Shared h80cpu bus types and command encodings, plus arbiter state and sizing constants.
package h80cpu_bus_arb_pkg;

  typedef logic [15:0] bus_addr_t;
  typedef logic [15:0] bus_data_t;
  typedef logic [2:0]  bus_cmd_t;

  localparam bus_cmd_t bus_cmd_read_w  = 3'd0;
  localparam bus_cmd_t bus_cmd_write_w = 3'd1;
  localparam bus_cmd_t bus_cmd_read_b  = 3'd2;
  localparam bus_cmd_t bus_cmd_write_b = 3'd3;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } arb_state_t;

  localparam int unsigned H80_ARB_MAX_NREQ = 4;

endpackage

// File: rtl/h80cpu_bus_arb_if.sv
// Requester-side and memory-side toggle-handshake signals of the shared h80cpu bus.
interface h80cpu_bus_arb_if
  import h80cpu_bus_arb_pkg::*;
#(
  parameter int unsigned NREQ = 2
) ();

  logic      [NREQ-1:0] req_run;
  bus_addr_t [NREQ-1:0] req_addr;
  bus_cmd_t  [NREQ-1:0] req_cmd;
  bus_data_t [NREQ-1:0] req_wr_data;
  bus_data_t [NREQ-1:0] req_rd_data;
  logic      [NREQ-1:0] req_done;

  bus_addr_t bus_addr;
  bus_cmd_t  bus_cmd;
  bus_data_t bus_wr_data;
  logic      bus_run;
  bus_data_t bus_rd_data;
  logic      bus_done;

  logic [1:0] grant;
  logic       busy;

  modport slave (
    input  req_run, req_addr, req_cmd, req_wr_data, bus_rd_data, bus_done,
    output req_rd_data, req_done, bus_addr, bus_cmd, bus_wr_data, bus_run, grant, busy
  );

  modport master (
    output req_run, req_addr, req_cmd, req_wr_data, bus_rd_data, bus_done,
    input  req_rd_data, req_done, bus_addr, bus_cmd, bus_wr_data, bus_run, grant, busy
  );

endinterface

// File: rtl/h80cpu_bus_arb_rr_pick.sv
// Round-robin picker: first pending index scanning upward from last+1, modulo NREQ.
module h80cpu_rr_pick
  import h80cpu_bus_arb_pkg::*;
#(
  parameter int unsigned NREQ = 2
) (
  input  logic [NREQ-1:0] i_pend,
  input  logic [1:0]      i_last,
  output logic            o_found,
  output logic [1:0]      o_idx
);

  logic [H80_ARB_MAX_NREQ-1:0] w_pend_ext;
  logic [1:0]                  w_c;

  always_comb begin
    w_pend_ext             = '0;
    w_pend_ext[NREQ-1:0]   = i_pend;
    o_found                = 1'b0;
    o_idx                  = '0;
    w_c                    = '0;
    // k = NREQ wraps back to last itself, so it is considered after all others
    for (int unsigned k = 1; k <= NREQ; k++) begin
      w_c = 2'((32'(i_last) + k) % NREQ);
      if (!o_found && w_pend_ext[w_c]) begin
        o_found = 1'b1;
        o_idx   = w_c;
      end
    end
  end

endmodule

// File: rtl/h80cpu_bus_arb.sv
// Round-robin arbiter sharing one toggle-handshake memory target between NREQ requesters.
module h80cpu_bus_arb
  import h80cpu_bus_arb_pkg::*;
#(
  parameter int unsigned NREQ = 2
) (
  input logic              clk,
  input logic              reset_,
  h80cpu_bus_arb_if.slave  bus
);

  arb_state_t r_state;
  arb_state_t w_next_state;

  logic [1:0]           r_last;
  logic [1:0]           r_grant;
  logic                 r_bus_run;
  logic [NREQ-1:0]      r_req_done;
  bus_data_t [NREQ-1:0] r_req_rd_data;
  bus_addr_t            r_bus_addr;
  bus_cmd_t             r_bus_cmd;
  bus_data_t            r_bus_wr_data;

  logic [NREQ-1:0] w_pend;
  logic            w_found;
  logic [1:0]      w_idx;
  logic            w_issue;
  logic            w_complete;
  bus_addr_t       w_sel_addr;
  bus_cmd_t        w_sel_cmd;
  bus_data_t       w_sel_wr_data;
  logic [NREQ-1:0] w_grant_oh;

  assign w_pend = bus.req_run ^ r_req_done;

  h80cpu_rr_pick #(
    .NREQ (NREQ)
  ) u_pick (
    .i_pend  (w_pend),
    .i_last  (r_last),
    .o_found (w_found),
    .o_idx   (w_idx)
  );

  always_comb begin
    w_next_state = r_state;
    w_issue      = 1'b0;
    w_complete   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_issue      = 1'b1;
          w_next_state = S_WAIT;
        end
      end
      S_WAIT: begin
        if (r_bus_run == bus.bus_done) begin
          w_complete   = 1'b1;
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Explicit muxes avoid indexing NREQ-wide vectors with the fixed 2-bit index
  always_comb begin
    w_sel_addr    = '0;
    w_sel_cmd     = '0;
    w_sel_wr_data = '0;
    w_grant_oh    = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (2'(i) == w_idx) begin
        w_sel_addr    = bus.req_addr[i];
        w_sel_cmd     = bus.req_cmd[i];
        w_sel_wr_data = bus.req_wr_data[i];
      end
      if (2'(i) == r_grant) begin
        w_grant_oh[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_last        <= 2'(NREQ - 1);
      r_grant       <= '0;
      r_bus_run     <= 1'b0;
      r_req_done    <= '0;
      r_req_rd_data <= '0;
      r_bus_addr    <= '0;
      r_bus_cmd     <= '0;
      r_bus_wr_data <= '0;
    end else begin
      if (w_issue) begin
        r_bus_addr    <= w_sel_addr;
        r_bus_cmd     <= w_sel_cmd;
        r_bus_wr_data <= w_sel_wr_data;
        r_grant       <= w_idx;
        r_bus_run     <= ~r_bus_run;
      end
      if (w_complete) begin
        for (int unsigned i = 0; i < NREQ; i++) begin
          if (w_grant_oh[i]) begin
            r_req_rd_data[i] <= bus.bus_rd_data;
          end
        end
        r_req_done <= r_req_done ^ w_grant_oh;
        r_last     <= r_grant;
      end
    end
  end

  assign bus.req_done    = r_req_done;
  assign bus.req_rd_data = r_req_rd_data;
  assign bus.bus_addr    = r_bus_addr;
  assign bus.bus_cmd     = r_bus_cmd;
  assign bus.bus_wr_data = r_bus_wr_data;
  assign bus.bus_run     = r_bus_run;
  assign bus.grant       = r_grant;
  assign bus.busy        = (r_state == S_WAIT);

endmodule

// File: tb/tb_h80cpu_bus_arb.sv
// Bench for h80cpu_bus_arb: toggle-handshake memory model plus a cycle-level transaction scoreboard.
module tb_h80cpu_bus_arb;
  import h80cpu_bus_arb_pkg::*;

  localparam int unsigned NREQ = 3;

  logic clk = 1'b0;
  logic reset_ = 1'b0;
  always #5 clk = ~clk;

  h80cpu_bus_arb_if #(.NREQ(NREQ)) bif ();

  h80cpu_bus_arb #(.NREQ(NREQ)) dut (
    .clk    (clk),
    .reset_ (reset_),
    .bus    (bif)
  );

  logic      [NREQ-1:0] tb_run = '0;
  bus_addr_t [NREQ-1:0] rq_addr = '0;
  bus_cmd_t  [NREQ-1:0] rq_cmd = '0;
  bus_data_t [NREQ-1:0] rq_wdata = '0;
  assign bif.req_run     = tb_run;
  assign bif.req_addr    = rq_addr;
  assign bif.req_cmd     = rq_cmd;
  assign bif.req_wr_data = rq_wdata;

  logic [15:0] mem     [0:32767];
  logic [15:0] ref_mem [0:32767];
  logic        m_done;
  bus_data_t   m_rdata;
  int          m_cnt;
  int          mem_lat = 1;
  assign bif.bus_done    = m_done;
  assign bif.bus_rd_data = m_rdata;

  // Memory target: performs the access mem_lat posedges after seeing run != done
  always @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      m_done <= 1'b0;
      m_cnt  <= 0;
    end else if (bif.bus_run != m_done) begin
      if (m_cnt + 1 >= mem_lat) begin
        m_cnt  <= 0;
        m_done <= bif.bus_run;
        case (bif.bus_cmd)
          bus_cmd_read_w:  m_rdata <= mem[bif.bus_addr[15:1]];
          bus_cmd_read_b:  m_rdata <= bif.bus_addr[0] ? {8'h00, mem[bif.bus_addr[15:1]][15:8]}
                                                      : {8'h00, mem[bif.bus_addr[15:1]][7:0]};
          bus_cmd_write_w: mem[bif.bus_addr[15:1]] <= bif.bus_wr_data;
          bus_cmd_write_b: begin
            if (bif.bus_addr[0]) mem[bif.bus_addr[15:1]][15:8] <= bif.bus_wr_data[7:0];
            else                 mem[bif.bus_addr[15:1]][7:0]  <= bif.bus_wr_data[7:0];
          end
          default: ;
        endcase
      end else begin
        m_cnt <= m_cnt + 1;
      end
    end
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bus_data_t ref_read(input bus_addr_t a, input bus_cmd_t c);
    bus_data_t w;
    w = ref_mem[a[15:1]];
    if (c == bus_cmd_read_b) return a[0] ? {8'h00, w[15:8]} : {8'h00, w[7:0]};
    return w;
  endfunction

  function automatic int rr_expect(input logic [NREQ-1:0] p, input int last);
    for (int k = 1; k <= int'(NREQ); k++) begin
      if (p[(last + k) % NREQ]) return (last + k) % NREQ;
    end
    return -1;
  endfunction

  // Scoreboard state: what the bus should look like, tracked per transaction
  logic [NREQ-1:0] issued = '0;
  logic [NREQ-1:0] model_done;
  logic            model_run, model_busy, mdone_prev;
  int model_g, ref_last, cyc = 0, grant_cyc;
  int done_cyc [NREQ];
  int glog [$];

  initial begin
    bit tog, exp_cmp, exp_gnt;
    int j;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (!reset_) begin
        model_done = '0;
        model_run  = 1'b0;
        model_busy = 1'b0;
        ref_last   = NREQ - 1;
      end else begin
        tog     = (bif.bus_run != model_run);
        exp_cmp = model_busy && (model_run == mdone_prev);
        exp_gnt = !model_busy && (issued != '0);
        chk("run_toggle", 32'(tog), 32'(exp_gnt));
        if (exp_cmp) model_done[model_g] = ~model_done[model_g];
        chk("req_done", 32'(bif.req_done), 32'(model_done));
        if (exp_cmp) begin
          if (rq_cmd[model_g] == bus_cmd_read_w || rq_cmd[model_g] == bus_cmd_read_b)
            chk("rd_data", 32'(bif.req_rd_data[model_g]), 32'(ref_read(rq_addr[model_g], rq_cmd[model_g])));
          else if (rq_cmd[model_g] == bus_cmd_write_w)
            ref_mem[rq_addr[model_g][15:1]] = rq_wdata[model_g];
          else if (rq_addr[model_g][0])
            ref_mem[rq_addr[model_g][15:1]][15:8] = rq_wdata[model_g][7:0];
          else
            ref_mem[rq_addr[model_g][15:1]][7:0] = rq_wdata[model_g][7:0];
          chk("latency", 32'(cyc - grant_cyc), 32'(mem_lat + 1));
          issued[model_g]   = 1'b0;
          ref_last          = model_g;
          model_busy        = 1'b0;
          done_cyc[model_g] = cyc;
        end
        if (exp_gnt) begin
          j = rr_expect(issued, ref_last);
          chk("grant", 32'(bif.grant), 32'(j));
          chk("bus_addr", 32'(bif.bus_addr), 32'(rq_addr[j]));
          chk("bus_cmd", 32'(bif.bus_cmd), 32'(rq_cmd[j]));
          chk("bus_wr_data", 32'(bif.bus_wr_data), 32'(rq_wdata[j]));
          model_run  = ~model_run;
          model_busy = 1'b1;
          model_g    = j;
          grant_cyc  = cyc;
          glog.push_back(j);
        end
        chk("busy", 32'(bif.busy), 32'(model_busy));
      end
      mdone_prev = m_done;
    end
  end

  task automatic issue(input int i, input bus_addr_t a, input bus_cmd_t c, input bus_data_t d);
    rq_addr[i]  = a;
    rq_cmd[i]   = c;
    rq_wdata[i] = d;
    tb_run[i]   = ~tb_run[i];
    issued[i]   = 1'b1;
  endtask

  task automatic wait_done(input int i);
    int t = 0;
    while (issued[i] && t < 300) begin
      @(posedge clk);
      #2;
      t++;
    end
    chk("timeout", 32'(issued[i]), 32'(0));
  endtask

  task automatic rand_req(input int i, input int n, input int gap);
    repeat (n) begin
      repeat ($urandom_range(0, gap)) @(negedge clk);
      @(negedge clk);
      issue(i, 16'h2000 + 16'($urandom_range(0, 15)), 3'($urandom_range(0, 3)), 16'($urandom));
      wait_done(i);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_ = 1'b0;
    tb_run = '0;
    issued = '0;
    #1;
    chk("rst_bus_run", 32'(bif.bus_run), 32'(0));
    chk("rst_req_done", 32'(bif.req_done), 32'(0));
    chk("rst_busy", 32'(bif.busy), 32'(0));
    chk("rst_grant", 32'(bif.grant), 32'(0));
    chk("rst_bus_addr", 32'(bif.bus_addr), 32'(0));
    chk("rst_bus_cmd", 32'(bif.bus_cmd), 32'(0));
    chk("rst_rd_data", 32'(bif.req_rd_data), 32'(0));
    repeat (2) @(negedge clk);
    reset_ = 1'b1;
  endtask

  initial begin
    for (int k = 0; k < 32768; k++) begin
      mem[k]     = 16'(k * 7 + 3);
      ref_mem[k] = 16'(k * 7 + 3);
    end
    mem[16'h1010]     = 16'h6548;
    ref_mem[16'h1010] = 16'h6548;

    do_reset();
    @(negedge clk);
    issue(0, 16'h2020, bus_cmd_read_w, 16'h0000);
    wait_done(0);
    chk("single_rd", 32'(bif.req_rd_data[0]), 32'h6548);

    // Same-cycle requests: requester 0 has priority after reset
    do_reset();
    @(negedge clk);
    issue(0, 16'h2000, bus_cmd_write_w, 16'h1234);
    issue(1, 16'h2000, bus_cmd_read_w, 16'h0000);
    fork
      wait_done(0);
      wait_done(1);
    join
    chk("simul_gap", 32'(done_cyc[1] - done_cyc[0]), 32'(3));
    chk("simul_rd", 32'(bif.req_rd_data[1]), 32'h1234);

    glog.delete();
    fork
      rand_req(0, 4, 0);
      rand_req(1, 4, 0);
    join
    chk("fair_count", 32'(glog.size()), 32'(8));
    for (int k = 1; k < glog.size(); k++) chk("fair_alt", 32'(glog[k] != glog[k-1]), 32'(1));

    @(negedge clk);
    issue(0, 16'h2000, bus_cmd_write_w, 16'h1234);
    wait_done(0);
    @(negedge clk);
    issue(0, 16'h2001, bus_cmd_write_b, 16'h55AB);
    wait_done(0);
    @(negedge clk);
    issue(1, 16'h2000, bus_cmd_read_w, 16'h0000);
    wait_done(1);
    chk("byte_word", 32'(bif.req_rd_data[1]), 32'hAB34);
    @(negedge clk);
    issue(1, 16'h2001, bus_cmd_read_b, 16'h0000);
    wait_done(1);
    chk("byte_rd", 32'(bif.req_rd_data[1]), 32'h00AB);

    // Abort a slow read with reset, then confirm normal service afterwards
    mem_lat = 5;
    @(negedge clk);
    issue(2, 16'h2020, bus_cmd_read_w, 16'h0000);
    begin
      int t = 0;
      while (!bif.busy && t < 20) begin
        @(negedge clk);
        t++;
      end
    end
    chk("busy_pre", 32'(bif.busy), 32'(1));
    do_reset();
    mem_lat = 1;
    @(negedge clk);
    issue(0, 16'h2020, bus_cmd_read_w, 16'h0000);
    wait_done(0);
    chk("post_rst_rd", 32'(bif.req_rd_data[0]), 32'h6548);

    mem_lat = 5;
    fork
      rand_req(0, 8, 3);
      rand_req(1, 8, 3);
      rand_req(2, 8, 3);
    join
    mem_lat = 2;
    fork
      rand_req(0, 25, 4);
      rand_req(1, 25, 4);
      rand_req(2, 25, 4);
    join
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/h80cpu_bus_arb.md
# h80cpu_bus_arb

Round-robin arbiter that shares one h80cpu toggle-handshake bus target (the `h80cpu_mem` memory) between `NREQ` requesters, for example the CPU core and a DMA/UART-loader engine. It sits between the requesters and the memory. It accepts one request at a time, forwards it with a single bus_run toggle, and returns the read data and a done toggle to the requester it granted. Each requester sees exactly the run/done toggle protocol it would see on a private bus.

## Interface
Parameters:
- NREQ, 2: number of requesters, legal range 2..4.

Ports:
- clk  in  1  single clock. All state updates on posedge.
- reset_  in  1  asynchronous, active-low reset.
- req_run  in  NREQ  per-requester run toggle. Requester i is pending while req_run[i] != req_done[i].
- req_addr  in  NREQ x bus_addr_t (16)  request address.
- req_cmd  in  NREQ x bus_cmd_t (3)  read_w / write_w / read_b / write_b.
- req_wr_data  in  NREQ x bus_data_t (16)  write data.
- req_rd_data  out  NREQ x bus_data_t  read result, valid from the cycle req_done[i] toggles.
- req_done  out  NREQ  per-requester done toggle.
- bus_addr  out  bus_addr_t  to memory.
- bus_cmd  out  bus_cmd_t  to memory.
- bus_wr_data  out  bus_data_t  to memory.
- bus_run  out  1  run toggle to memory.
- bus_rd_data  in  bus_data_t  from memory.
- bus_done  in  1  done toggle from memory.
- grant  out  2  index of the current or last granted requester.
- busy  out  1  high while a transaction is outstanding (state S_WAIT).

## Operation
- States are S_IDLE and S_WAIT.
- **S_IDLE:**
  - Compute the pending vector p[i] = req_run[i] ^ req_done[i].
  - If p == 0, stay in S_IDLE.
  - Otherwise select the first pending index scanning from last+1 upward, modulo NREQ.
  - Latch req_addr, req_cmd and req_wr_data of the selected index into bus_addr, bus_cmd and bus_wr_data.
  - Set grant to the selected index, invert bus_run, and go to S_WAIT.
- **S_WAIT:**
  - Stay while bus_run != bus_done.
  - When they are equal:
    - req_rd_data[grant] <= bus_rd_data (for write commands the value is don't-care but still updated).
    - Invert req_done[grant].
    - last <= grant.
    - Go to S_IDLE.
- Requester obligations:
  - Hold addr, cmd and wr_data stable from its run toggle until its done toggle.
  - Do not toggle run again while pending.
  - A violation is undefined behaviour and needs no detection.
- The arbiter never reorders or merges requests and has one outstanding transaction at most.
- bus_cmd is passed through unchanged. Byte/word handling stays in the memory.
- Starvation-free: a pending requester is granted within NREQ-1 other transactions.

## Timing
- Reset (async assert, release synchronous to clk):
  - state = S_IDLE.
  - bus_run = 0, req_done = 0, req_rd_data = 0.
  - bus_addr, bus_cmd and bus_wr_data = 0.
  - grant = 0, last = NREQ-1 (requester 0 has first priority), busy = 0.
- Reset mid-transaction aborts it. The memory must be reset by the same event so that bus_done returns to 0 together with bus_run.
- Grant latency: a pending edge that is visible at posedge N toggles bus_run at N, which takes 1 cycle.
- Completion: bus_done observed equal at posedge M toggles req_done at M.
- Total overhead is 2 cycles plus the memory latency.
- Back-to-back: the next grant is issued at the posedge after completion (one S_IDLE cycle). The maximum rate is therefore 1 transaction per 3 cycles against a 1-cycle memory.
- Simultaneous requests in one cycle: the round-robin order decides. The loser stays pending, with no loss.
- A requester's run toggle that arrives in the same cycle as its own completion is seen as a new request on the next S_IDLE evaluation.
- Toggle comparisons are pure XOR. Wrap-around is not possible with 1-bit toggles.

## Structure
- Shared package/header `h80cpu.svh`:
  - bus_addr_t, bus_cmd_t, bus_data_t and the bus_cmd_* constants, which already exist.
  - Add arb_state_t {S_IDLE, S_WAIT} and H80_ARB_MAX_NREQ = 4.
- Sub-module `h80cpu_rr_pick`: purely combinational. Inputs are the pending vector and last; outputs are found and idx. It is reused by future IO-bus sharing.
- The top instantiates one picker and one two-state FSM.

## Test plan
- **Single read:** reset, mem[0x1010] = 0x6548; toggle req_run[0] with read_w @0x2020 -> bus_run toggles at the next posedge, then req_done[0] toggles with req_rd_data[0] = 0x6548, and busy clears.
- **Simultaneous:** req_run[0] and req_run[1] toggle in the same cycle (write_w 0x1234 @0x2000 and read_w @0x2000) -> requester 0 is served first, then requester 1 reads 0x1234, and req_done[1] toggles exactly 3 cycles after req_done[0].
- **Fairness:** requester 0 re-requests immediately after each done for 8 transactions while requester 1 is pending -> grants alternate 0,1,0,1 and requester 1 is never skipped.
- **Byte ops:** write_b 0xAB @0x2001, then read_w @0x2000 via requester 1 -> 0xABxx with the low byte preserved.
- **Reset mid-transaction:** assert reset_ while busy=1 -> bus_run, req_done and busy are 0 immediately. After release, a new read completes normally.
- **Slow target:** a memory model with 5-cycle latency -> bus_run stays toggled for 5 cycles, req_done[i] toggles only after bus_done, and no other grant is issued meanwhile.
